// File: rtl/drain_pkg.sv
// rtl/drain_pkg.sv - shared types and constants for the output buffer drain
package drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } drain_state_t;

  localparam int BEATS_PER_TILE = 4;
  localparam int NUM_TILES      = 32;

  typedef logic [1:0] sub_idx_t;
  typedef logic [2:0] unit_idx_t;
  typedef logic [1:0] beat_idx_t;
  typedef logic [4:0] tile_idx_t;

  // Tile number is sub*8 + unit, which is a plain concatenation for 8 unit tiles.
  function automatic tile_idx_t tile_of(input sub_idx_t sub, input unit_idx_t unit);
    return {sub, unit};
  endfunction

endpackage

// File: rtl/output_drain_if.sv
// rtl/output_drain_if.sv - beat stream from the drain toward writeback/DMA
interface output_drain_if
  import drain_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BEAT_LANES = 16
);

  logic                         m_valid;
  logic                         m_ready;
  logic [BEAT_LANES*DATA_W-1:0] m_data;
  beat_idx_t                    m_beat;
  tile_idx_t                    m_tile;
  logic                         m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_beat,
    output m_tile,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_beat,
    input  m_tile,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/drain_beat_mux.sv
// rtl/drain_beat_mux.sv - picks one beat's lanes out of the captured buffer word
module drain_beat_mux
  import drain_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LANES      = 64,
  parameter int BEAT_LANES = 16
) (
  input  logic [LANES*DATA_W-1:0]      cap,
  input  beat_idx_t                    beat,
  output logic [BEAT_LANES*DATA_W-1:0] data
);

  localparam int BEAT_W    = BEAT_LANES * DATA_W;
  localparam int NUM_BEATS = LANES / BEAT_LANES;

  always_comb begin
    data = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (beat == beat_idx_t'(b)) begin
        data = cap[b*BEAT_W +: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - walks all 32 output tiles, reads each once and streams it as 4 beats
module output_drain
  import drain_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LANES      = 64,
  parameter int BEAT_LANES = 16,
  parameter int SUB_TILES  = 4,
  parameter int UNIT_TILES = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    output_read_en,
  output sub_idx_t                sub_tile_idx,
  output unit_idx_t               unit_tile_idx,
  input  logic [LANES*DATA_W-1:0] rd_data,
  output_drain_if.master          strm
);

  localparam int WORD_W = LANES * DATA_W;
  localparam int BEAT_W = BEAT_LANES * DATA_W;

  drain_state_t      state_q;
  drain_state_t      state_d;
  sub_idx_t          sub_q;
  unit_idx_t         unit_q;
  beat_idx_t         beat_q;
  logic [2:0]        wait_q;
  logic [WORD_W-1:0] cap_q;
  logic [BEAT_W-1:0] beat_data;

  logic send;
  logic send_hs;
  logic last_beat;
  logic last_unit;
  logic last_tile;
  logic wait_last;

  assign send      = (state_q == ST_SEND);
  assign send_hs   = send && strm.m_ready;
  assign last_beat = (beat_q == beat_idx_t'(BEATS_PER_TILE - 1));
  assign last_unit = (unit_q == unit_idx_t'(UNIT_TILES - 1));
  assign last_tile = last_unit && (sub_q == sub_idx_t'(SUB_TILES - 1));
  assign wait_last = (wait_q == 3'(READ_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    done           = 1'b0;
    output_read_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        busy           = 1'b1;
        output_read_en = 1'b1;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (wait_last) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        busy = 1'b1;
        if (send_hs && last_beat) begin
          state_d = last_tile ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tile counters only move on the final beat handshake of a tile, so the
  // read address and m_tile agree for the whole REQ..SEND span of that tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q  <= '0;
      unit_q <= '0;
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sub_q  <= '0;
            unit_q <= '0;
            beat_q <= '0;
          end
        end
        ST_REQ: begin
          wait_q <= '0;
        end
        ST_WAIT: begin
          wait_q <= wait_q + 3'd1;
          beat_q <= '0;
        end
        ST_SEND: begin
          if (send_hs) begin
            if (!last_beat) begin
              beat_q <= beat_q + 2'd1;
            end else if (!last_tile) begin
              beat_q <= '0;
              if (last_unit) begin
                unit_q <= '0;
                sub_q  <= sub_q + 2'd1;
              end else begin
                unit_q <= unit_q + 3'd1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture only on the cycle the buffer data is guaranteed valid; rd_data is
  // ignored at all other times.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_WAIT && wait_last) begin
      cap_q <= rd_data;
    end
  end

  drain_beat_mux #(
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .BEAT_LANES (BEAT_LANES)
  ) u_beat_mux (
    .cap  (cap_q),
    .beat (beat_q),
    .data (beat_data)
  );

  assign sub_tile_idx  = sub_q;
  assign unit_tile_idx = unit_q;

  assign strm.m_valid = send;
  assign strm.m_data  = send ? beat_data : '0;
  assign strm.m_beat  = send ? beat_q : '0;
  assign strm.m_tile  = send ? tile_of(sub_q, unit_q) : '0;
  assign strm.m_last  = send && last_beat && last_tile;

endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - scoreboard bench for output_drain at READ_LAT 1 and 3
module tb_output_drain;
  import drain_pkg::*;

  localparam int DATA_W     = 32;
  localparam int LANES      = 64;
  localparam int BEAT_LANES = 16;
  localparam int RD_W       = LANES * DATA_W;
  localparam int BW         = BEAT_LANES * DATA_W;
  localparam int CW         = 640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [1:0] ready_v;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    $display("FAIL %s: got %0d, required event did not occur as expected", name, act);
  endtask

  function automatic logic [31:0] lane_val(input int tile, input int lane);
    return {tile[15:0], lane[15:0]};
  endfunction

  function automatic logic [BW-1:0] beat_val(input int tile, input int beat);
    logic [BW-1:0] r;
    for (int k = 0; k < BEAT_LANES; k++) r[k*32 +: 32] = lane_val(tile, 16*beat + k);
    return r;
  endfunction

  function automatic logic [RD_W-1:0] word_val(input int tile);
    logic [RD_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*32 +: 32] = lane_val(tile, k);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_lat
    localparam int LAT = (g == 0) ? 1 : 3;

    logic            busy, done, read_en;
    sub_idx_t        sub;
    unit_idx_t       unit;
    logic [RD_W-1:0] rd_data;
    logic [RD_W-1:0] junk;
    logic            pv [LAT] = '{default: 1'b0};
    int              pt [LAT] = '{default: 0};

    output_drain_if #(.DATA_W(DATA_W), .BEAT_LANES(BEAT_LANES)) sif ();
    assign sif.m_ready = ready_v[g];

    output_drain #(
      .DATA_W(DATA_W), .LANES(LANES), .BEAT_LANES(BEAT_LANES),
      .SUB_TILES(4), .UNIT_TILES(8), .READ_LAT(LAT)
    ) dut (
      .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .busy(busy), .done(done),
      .output_read_en(read_en), .sub_tile_idx(sub), .unit_tile_idx(unit),
      .rd_data(rd_data), .strm(sif)
    );

    // Buffer model: real data exactly LAT cycles after a strobe, junk otherwise.
    always @(posedge clk) begin
      pv[0] <= read_en;
      pt[0] <= int'({sub, unit});
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      for (int l = 0; l < LANES; l++) junk[l*32 +: 32] <= $urandom;
    end
    assign rd_data = pv[LAT-1] ? word_val(pt[LAT-1]) : junk;

    int exp_t[$];
    int exp_b[$];
    int rd_q[$];
    int done_cnt  = 0;
    int done_at   = -1;
    int stalls    = 0;
    int start_cyc = 0;

    initial begin
      bit            running;
      bit            prev_stall;
      logic [CW-1:0] hold;
      logic [CW-1:0] cur;
      int            t, b;
      running    = 1'b0;
      prev_stall = 1'b0;
      hold       = '0;
      forever begin
        @(negedge clk);
        if (rst_v[g]) begin
          exp_t.delete();
          exp_b.delete();
          rd_q.delete();
          running    = 1'b0;
          prev_stall = 1'b0;
        end else begin
          if (start_v[g] && !running) begin
            for (int tt = 0; tt < 32; tt++) begin
              rd_q.push_back(tt);
              for (int bb = 0; bb < 4; bb++) begin
                exp_t.push_back(tt);
                exp_b.push_back(bb);
              end
            end
            running   = 1'b1;
            start_cyc = cyc;
            stalls    = 0;
          end
          if (read_en) begin
            if (rd_q.size() == 0) fail_now("read_unexpected", int'({sub, unit}));
            else chk("read_addr", {sub, unit}, rd_q.pop_front());
          end
          cur = {sif.m_last, sif.m_tile, sif.m_beat, sif.m_data};
          if (sif.m_valid) begin
            if (prev_stall) chk("stall_hold", cur, hold);
            if (sif.m_ready) begin
              if (exp_t.size() == 0) begin
                fail_now("beat_unexpected", int'(sif.m_tile));
              end else begin
                t = exp_t.pop_front();
                b = exp_b.pop_front();
                chk("beat_data", sif.m_data, beat_val(t, b));
                chk("beat_idx", sif.m_beat, b);
                chk("beat_tile", sif.m_tile, t);
                chk("beat_last", sif.m_last, (t == 31 && b == 3));
                if (t == 31 && b == 3) running = 1'b0;
              end
              prev_stall = 1'b0;
            end else begin
              stalls++;
              prev_stall = 1'b1;
              hold       = cur;
            end
          end else if (prev_stall) begin
            fail_now("valid_dropped", 0);
            prev_stall = 1'b0;
          end
          if (done) begin
            done_cnt++;
            done_at = cyc - start_cyc;
            chk("busy_at_done", busy, 1);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int pulses;
    int dc;
    rst_v   = 2'b11;
    start_v = 2'b00;
    ready_v = 2'b11;
    repeat (3) step();

    chk("rst_busy", gen_lat[0].busy, 0);
    chk("rst_done", gen_lat[0].done, 0);
    chk("rst_read_en", gen_lat[0].read_en, 0);
    chk("rst_idx", {gen_lat[0].sub, gen_lat[0].unit}, 0);
    chk("rst_valid", gen_lat[0].sif.m_valid, 0);
    chk("rst_data", gen_lat[0].sif.m_data, 0);
    chk("rst_meta", {gen_lat[0].sif.m_last, gen_lat[0].sif.m_tile, gen_lat[0].sif.m_beat}, 0);
    chk("rst_busy_lat3", gen_lat[1].busy, 0);
    rst_v = 2'b00;
    step();

    // Full drain, READ_LAT=1, ready held high.
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("c1_read_en", gen_lat[0].read_en, 1);
    chk("c1_busy", gen_lat[0].busy, 1);
    chk("c1_idx", {gen_lat[0].sub, gen_lat[0].unit}, 0);
    k = 0;
    while (gen_lat[0].done_cnt < 1 && k < 400) begin step(); k++; end
    if (gen_lat[0].done_cnt < 1) fail_now("p1_timeout", k);
    chk("p1_done_cycle", gen_lat[0].done_at, 193);
    chk("p1_stalls", gen_lat[0].stalls, 0);
    chk("p1_beats_left", gen_lat[0].exp_t.size(), 0);
    chk("p1_reads_left", gen_lat[0].rd_q.size(), 0);
    chk("p1_idle_busy", gen_lat[0].busy, 0);
    chk("p1_done_pulse", gen_lat[0].done, 0);

    // Random backpressure with stray start pulses during SEND.
    step();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    pulses = 0;
    k = 0;
    while (gen_lat[0].done_cnt < 2 && k < 3000) begin
      ready_v[0] = 1'($urandom_range(0, 1));
      start_v[0] = gen_lat[0].sif.m_valid && pulses < 4 && $urandom_range(0, 3) == 0;
      if (start_v[0]) pulses++;
      step();
      k++;
    end
    ready_v[0] = 1'b1;
    start_v[0] = 1'b0;
    if (gen_lat[0].done_cnt < 2) fail_now("p2_timeout", k);
    chk("p2_done_cycle", gen_lat[0].done_at, 193 + gen_lat[0].stalls);
    chk("p2_beats_left", gen_lat[0].exp_t.size(), 0);
    chk("p2_reads_left", gen_lat[0].rd_q.size(), 0);
    chk("p2_done_count", gen_lat[0].done_cnt, 2);

    // READ_LAT=3 with junk on rd_data outside the valid cycle.
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    k = 0;
    while (gen_lat[1].done_cnt < 1 && k < 600) begin step(); k++; end
    if (gen_lat[1].done_cnt < 1) fail_now("p3_timeout", k);
    chk("p3_done_cycle", gen_lat[1].done_at, 257);
    chk("p3_beats_left", gen_lat[1].exp_t.size(), 0);
    chk("p3_reads_left", gen_lat[1].rd_q.size(), 0);

    // Reset at beat 2 of tile 5, then restart from (0,0).
    step();
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    k = 0;
    while (!(gen_lat[0].sif.m_valid && gen_lat[0].sif.m_tile == 5 && gen_lat[0].sif.m_beat == 2)
           && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) fail_now("p4_no_tile5", k);
    dc = gen_lat[0].done_cnt;
    rst_v[0] = 1'b1;
    step();
    chk("mid_rst_busy", gen_lat[0].busy, 0);
    chk("mid_rst_valid", gen_lat[0].sif.m_valid, 0);
    chk("mid_rst_data", gen_lat[0].sif.m_data, 0);
    chk("mid_rst_meta", {gen_lat[0].sif.m_last, gen_lat[0].sif.m_tile, gen_lat[0].sif.m_beat}, 0);
    chk("mid_rst_rd", {gen_lat[0].read_en, gen_lat[0].sub, gen_lat[0].unit}, 0);
    chk("mid_rst_done", gen_lat[0].done, 0);
    rst_v[0] = 1'b0;
    repeat (5) step();
    chk("mid_rst_no_done", gen_lat[0].done_cnt, dc);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("p5_first_idx", {gen_lat[0].read_en, gen_lat[0].sub, gen_lat[0].unit}, 6'b100000);
    k = 0;
    while (gen_lat[0].done_cnt < dc + 1 && k < 400) begin step(); k++; end
    if (gen_lat[0].done_cnt < dc + 1) fail_now("p5_timeout", k);
    chk("p5_done_cycle", gen_lat[0].done_at, 193);
    chk("p5_beats_left", gen_lat[0].exp_t.size(), 0);
    chk("p5_reads_left", gen_lat[0].rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
